// File: rtl/audio_sfx_arbiter.sv
// Shares the tone PWM between music passthrough and three prioritized sound effects.
// Define AUDIO_SFX_DUCK_EN to drive music_hold from the effect-busy state; otherwise it is tied low.
module audio_sfx_arbiter #(
  parameter int TICK_DIV = 6_250_000,
  parameter int TONE_W   = 28
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TONE_W-1:0] music_tone,
  input  logic              music_en,
  input  logic              mute,
  input  logic [2:0]        sfx_req,
  output logic [TONE_W-1:0] tone,
  output logic              sfx_busy,
  output logic [1:0]        sfx_id,
  output logic              music_hold
);

  localparam logic       S_IDLE    = 1'b0;
  localparam logic       S_PLAY    = 1'b1;
  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  logic        state, nxt_state;
  logic [1:0]  cur_id, nxt_id, req_id;
  logic [2:0]  note_idx, nxt_idx;
  logic [23:0] tick_cnt, nxt_tick;
  logic [TONE_W-1:0] nxt_tone;

  function automatic logic [TONE_W-1:0] note_hz(input logic [1:0] id, input logic [2:0] idx);
    logic [TONE_W-1:0] hz;
    hz = '0;
    case ({id, idx})
      {2'd1, 3'd0}: hz = TONE_W'(1047);
      {2'd2, 3'd0}, {2'd2, 3'd1},
      {2'd2, 3'd3}, {2'd2, 3'd4}: hz = TONE_W'(196);
      {2'd3, 3'd0}: hz = TONE_W'(523);
      {2'd3, 3'd1}: hz = TONE_W'(659);
      {2'd3, 3'd2}: hz = TONE_W'(784);
      {2'd3, 3'd3}, {2'd3, 3'd4},
      {2'd3, 3'd5}: hz = TONE_W'(1047);
      default:      hz = '0;
    endcase
    return hz;
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] id);
    logic [2:0] li;
    case (id)
      2'd2:    li = 3'd4;
      2'd3:    li = 3'd5;
      default: li = 3'd0;
    endcase
    return li;
  endfunction

  always_comb begin
    req_id = 2'd0;
    if (sfx_req[2])      req_id = 2'd3;
    else if (sfx_req[1]) req_id = 2'd2;
    else if (sfx_req[0]) req_id = 2'd1;

    nxt_state = state;
    nxt_id    = cur_id;
    nxt_idx   = note_idx;
    nxt_tick  = tick_cnt;
    // Equal-or-higher request restarts, even on the final tick, so back-to-back effects leave no gap
    if (req_id != 2'd0 && (state == S_IDLE || req_id >= cur_id)) begin
      nxt_state = S_PLAY;
      nxt_id    = req_id;
      nxt_idx   = 3'd0;
      nxt_tick  = 24'd0;
    end else if (state == S_PLAY) begin
      if (tick_cnt == TICK_LAST) begin
        nxt_tick = 24'd0;
        if (note_idx == last_idx(cur_id)) begin
          nxt_state = S_IDLE;
          nxt_id    = 2'd0;
          nxt_idx   = 3'd0;
        end else begin
          nxt_idx = note_idx + 3'd1;
        end
      end else begin
        nxt_tick = tick_cnt + 24'd1;
      end
    end

    nxt_tone = '0;
    if (!mute) begin
      if (nxt_state == S_PLAY) nxt_tone = note_hz(nxt_id, nxt_idx);
      else if (music_en)       nxt_tone = music_tone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cur_id   <= 2'd0;
      note_idx <= 3'd0;
      tick_cnt <= 24'd0;
      tone     <= '0;
      sfx_busy <= 1'b0;
      sfx_id   <= 2'd0;
    end else begin
      state    <= nxt_state;
      cur_id   <= nxt_id;
      note_idx <= nxt_idx;
      tick_cnt <= nxt_tick;
      tone     <= nxt_tone;
      sfx_busy <= (nxt_state == S_PLAY);
      sfx_id   <= (nxt_state == S_PLAY) ? nxt_id : 2'd0;
    end
  end

`ifdef AUDIO_SFX_DUCK_EN
  always_ff @(posedge clk) begin
    if (reset) music_hold <= 1'b0;
    else       music_hold <= (nxt_state == S_PLAY);
  end
`else
  assign music_hold = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sfx_arbiter.sv
// Randomized and scenario-driven bench for audio_sfx_arbiter against an elapsed-time reference model.
module tb_audio_sfx_arbiter;
  localparam int TD = 4;
  localparam int TW = 28;

  logic          clk = 1'b0;
  logic          reset;
  logic [TW-1:0] music_tone;
  logic          music_en;
  logic          mute;
  logic [2:0]    sfx_req;
  logic [TW-1:0] tone;
  logic          sfx_busy;
  logic [1:0]    sfx_id;
  logic          music_hold;

  always #5 clk = ~clk;

  audio_sfx_arbiter #(.TICK_DIV(TD), .TONE_W(TW)) dut (
    .clk(clk), .reset(reset), .music_tone(music_tone), .music_en(music_en),
    .mute(mute), .sfx_req(sfx_req), .tone(tone), .sfx_busy(sfx_busy),
    .sfx_id(sfx_id), .music_hold(music_hold)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: active effect and cycles elapsed since it started
  int m_id = 0;
  int m_el = 0;

  logic          g_mute = 1'b0;
  logic          g_en   = 1'b0;
  logic [TW-1:0] g_mt   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int len_of(input int id);
    case (id)
      1: return 1;
      2: return 5;
      3: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int note_of(input int id, input int n);
    int err_t[5] = '{196, 196, 0, 196, 196};
    int win_t[6] = '{523, 659, 784, 1047, 1047, 1047};
    case (id)
      1: return 1047;
      2: return err_t[n];
      3: return win_t[n];
      default: return 0;
    endcase
  endfunction

  task automatic cyc(input logic rst, input logic [2:0] req);
    int r;
    int e_tone;
    @(negedge clk);
    reset = rst; sfx_req = req; mute = g_mute; music_en = g_en; music_tone = g_mt;
    @(posedge clk);
    r = req[2] ? 3 : req[1] ? 2 : req[0] ? 1 : 0;
    if (rst) begin
      m_id = 0; m_el = 0;
    end else if (r != 0 && r >= m_id) begin
      m_id = r; m_el = 0;
    end else if (m_id != 0) begin
      m_el++;
      if (m_el == len_of(m_id) * TD) begin m_id = 0; m_el = 0; end
    end
    if (rst || g_mute)  e_tone = 0;
    else if (m_id != 0) e_tone = note_of(m_id, m_el / TD);
    else                e_tone = g_en ? int'(g_mt) : 0;
    #1;
    check("tone", 32'(tone), e_tone);
    check("busy", 32'(sfx_busy), (m_id != 0) ? 1 : 0);
    check("id", 32'(sfx_id), m_id);
`ifdef AUDIO_SFX_DUCK_EN
    check("hold", 32'(music_hold), (m_id != 0) ? 1 : 0);
`else
    check("hold", 32'(music_hold), 0);
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'b000);
  endtask

  initial begin
    reset = 1'b1; sfx_req = '0; mute = 1'b0; music_en = 1'b0; music_tone = '0;
    cyc(1'b1, 3'b000);
    cyc(1'b1, 3'b111);
    check("rst_tone", 32'(tone), 0);

    g_en = 1'b1; g_mt = TW'(440);
    idle(3);
    check("pass_440", 32'(tone), 440);

    // Click alone
    cyc(1'b0, 3'b001);
    check("click_tone", 32'(tone), 1047);
    idle(5);
    // Error sequence
    cyc(1'b0, 3'b010);
    idle(22);
    // Two requests together, lower ignored during error, win preempts at note 1
    cyc(1'b0, 3'b011);
    check("prio_id", 32'(sfx_id), 2);
    idle(2);
    cyc(1'b0, 3'b001);
    check("click_drop", 32'(sfx_id), 2);
    idle(3);
    cyc(1'b0, 3'b100);
    check("preempt_tone", 32'(tone), 523);
    idle(26);
    // Error restarted by error
    cyc(1'b0, 3'b010);
    idle(9);
    cyc(1'b0, 3'b010);
    idle(22);
    // Win on the final tick of click
    cyc(1'b0, 3'b001);
    idle(3);
    cyc(1'b0, 3'b100);
    check("chain_busy", 32'(sfx_busy), 1);
    check("chain_tone", 32'(tone), 523);
    idle(26);
    // Mute during win
    cyc(1'b0, 3'b100);
    idle(3);
    g_mute = 1'b1;
    idle(6);
    check("mute_tone", 32'(tone), 0);
    g_mute = 1'b0;
    idle(18);
    // Reset at win note 2, with a request in the reset cycle
    cyc(1'b0, 3'b100);
    idle(2 * TD);
    check("at_note2", 32'(tone), 784);
    cyc(1'b1, 3'b100);
    check("rst_mid_busy", 32'(sfx_busy), 0);
    g_en = 1'b1; g_mt = TW'(440);
    cyc(1'b0, 3'b000);
    check("rst_release", 32'(tone), 440);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] rq;
      rq = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b000;
      g_mute = ($urandom_range(0, 15) == 0);
      g_en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) g_mt = TW'($urandom);
      cyc(($urandom_range(0, 199) == 0), rq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/audio_sfx_arbiter.md
# audio_sfx_arbiter

Shares the single tone PWM generator between background music and three prioritized sound effects (key click, error buzz, win jingle) for the Sudoku audio path. Sits between the Music ROM tone output and the tone-PWM frequency input. Sequences each effect's note list on its own tick timer and can hold the music player while an effect plays. Every output is registered.

## Interface
Parameters:
- `TICK_DIV`, 6_250_000: clk cycles per effect note (16 notes/s at 100 MHz); legal range 2..2^24.
- `TONE_W`, 28: tone frequency width, matching the PWM `freq` input.

Ports:
- `clk`  in  1  system clock; sole clock of the block.
- `reset`  in  1  synchronous, active-high reset.
- `music_tone`  in  TONE_W  current music note frequency in Hz; 0 = rest.
- `music_en`  in  1  1 = pass music through when no effect is active; 0 = silence.
- `mute`  in  1  forces `tone` to 0; sequencing continues.
- `sfx_req`  in  3  one-cycle request pulses: bit0 click, bit1 error, bit2 win.
- `tone`  out  TONE_W  frequency to the tone PWM; 0 = silent.
- `sfx_busy`  out  1  an effect is playing.
- `sfx_id`  out  2  active effect: 0 none, 1 click, 2 error, 3 win.
- `music_hold`  out  1  pause request to the music player (see Configuration).

## Operation
- States: IDLE and PLAY. Internal registers: `cur_id`, `note_idx` (3 bits), `tick_cnt` (24 bits).
- Priority: win (3) > error (2) > click (1). When several `sfx_req` bits are set in one cycle, only the highest is taken.
- IDLE: `tone <= mute ? 0 : (music_en ? music_tone : 0)`. A request moves the block to PLAY with `cur_id` = requested id, `note_idx = 0`, `tick_cnt = 0`.
- PLAY: `tone <= mute ? 0 : note(cur_id, note_idx)`. `tick_cnt` increments each cycle. When it reaches TICK_DIV-1 it clears to 0 and `note_idx` increments. After the last note of the effect completes, the block returns to IDLE.
- Note tables, in Hz, 0 = rest:
  - click (1 note): 1047.
  - error (5 notes): 196, 196, 0, 196, 196.
  - win (6 notes): 523, 659, 784, 1047, 1047, 1047.
- Preemption in PLAY:
  - A request with id greater than or equal to `cur_id` restarts the sequencer on the new id at note 0 with `tick_cnt = 0`.
  - A request with lower id is dropped; it is not queued.
- `sfx_busy = (state == PLAY)`. `sfx_id = cur_id` in PLAY, otherwise 0.
- Reset, at any point including mid-effect:
  - Outputs: `tone = 0`, `sfx_busy = 0`, `sfx_id = 0`, `music_hold = 0`.
  - Internal: state IDLE, all counters 0.
  - Requests present in the reset cycle are ignored.

## Timing
- Request sampled at cycle N: at N+1 `sfx_busy = 1`, `sfx_id` is valid and `tone` = first note.
- Each note is held for exactly TICK_DIV cycles. An effect of K notes keeps `sfx_busy` high for exactly K*TICK_DIV cycles.
- On the cycle after the last note ends: `sfx_busy = 0`, `sfx_id = 0`, and `tone` = music value registered from that cycle.
- Request in the same cycle as the final tick of the current effect: the request wins. The new effect starts at the next cycle and `sfx_busy` stays high with no gap.
- Music passthrough latency is 1 cycle. `mute` takes effect 1 cycle after assertion.

## Configuration
- Macro `AUDIO_SFX_DUCK_EN`.
- Defined: `music_hold` is registered and equals `sfx_busy` at the same cycle, so the music player freezes on its current beat and resumes from that beat after the effect.
- Undefined: `music_hold` is tied to 0. Music keeps advancing underneath the effect and only `tone` is overridden.

## Test plan
Run with TICK_DIV=4.
- Reset mid-win: assert `reset` while at win note 2 -> next cycle `tone = 0`, `sfx_busy = 0`, `sfx_id = 0`, `music_hold = 0`. After reset release with `music_en = 1` and `music_tone = 440` -> `tone = 440` one cycle later.
- Click alone: `sfx_req = 3'b001` at cycle N -> `tone = 1047` and `sfx_id = 1` over N+1..N+4. At N+5 `tone = music_tone` and `sfx_busy = 0`.
- Error sequence: `sfx_req = 3'b010` -> `tone` goes 196 (4 cycles), 196 (4), 0 (4), 196 (4), 196 (4); `sfx_busy` high for exactly 20 cycles.
- Priority and preemption:
  - `sfx_req = 3'b011` in one cycle -> error plays.
  - Click pulsed during error -> ignored.
  - Win pulsed during error note 1 -> next cycle `tone = 523` and `sfx_id = 3`.
  - Error repeated during error -> restarts at note 0.
- Boundary: win pulsed on the final tick of click -> `sfx_busy` never drops and `tone = 523` on the following cycle.
- Mute and duck:
  - `mute = 1` during win -> `tone = 0` while `sfx_busy` and `note_idx` progress normally.
  - With `AUDIO_SFX_DUCK_EN` defined -> `music_hold` equals `sfx_busy` on every cycle.
  - Without the macro -> `music_hold` stays 0 throughout.
